// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480@60 default timing, 3-3-2 colour layout.
package vga_pkg;

    // Default 640x480@60 raster (pixel clock 25 MHz from 100 MHz / 4)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIX_DIV  = 4;

    // Colour field widths on the pins
    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int RGB_W = R_W + G_W + B_W;

    // Renderer colour word, {R,G,B} from MSB down
    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate strobe divider: one-cycle strobe every PIX_DIV enabled cycles.
module vga_pix_div #(
    parameter int PIX_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic stb
);

    localparam int            DW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);

    logic [DW-1:0] div;

    // Free-running modulo-PIX_DIV count; clear pins it at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div <= '0;
        else if (clr)
            div <= '0;
        else if (en)
            div <= (div == LAST) ? '0 : div + DW'(1);
    end

    // With PIX_DIV=1 the count stays at 0 and the strobe follows en
    assign stb = en && !clr && (div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered 3-3-2 colour and sync pins.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_DIV  = DEF_PIX_DIV,
    parameter int CW       = 10,
    parameter int FCW      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [RGB_W-1:0] i_rgb,
    output logic             o_pix_stb,
    output logic [CW-1:0]    o_x,
    output logic [CW-1:0]    o_y,
    output logic             o_active,
    output logic             o_line_start,
    output logic             o_frame_start,
    output logic [FCW-1:0]   o_frame_cnt,
    output logic             VGA_HS_O,
    output logic             VGA_VS_O,
    output logic [R_W-1:0]   VGA_R_O,
    output logic [G_W-1:0]   VGA_G_O,
    output logic [B_W-1:0]   VGA_B_O
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SS    = H_ACTIVE + H_FP;
    localparam int H_SE    = H_SS + H_SYNC;
    localparam int V_SS    = V_ACTIVE + V_FP;
    localparam int V_SE    = V_SS + V_SYNC;

    logic [CW-1:0] h, v;
    logic [31:0]   hw, vw;
    logic          stb, h_last, v_last, hsync, vsync;
    rgb_t          pix_q;
    logic          hs_q, vs_q;

    vga_pix_div #(.PIX_DIV(PIX_DIV)) u_div (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (i_en),
        .clr   (!i_en),
        .stb   (stb)
    );

    // Region decode done at 32 bits so a sync end equal to 2^CW cannot overflow
    assign hw     = 32'(h);
    assign vw     = 32'(v);
    assign h_last = (h == CW'(H_TOTAL - 1));
    assign v_last = (v == CW'(V_TOTAL - 1));
    assign hsync  = (hw >= 32'(H_SS)) && (hw < 32'(H_SE));
    assign vsync  = (vw >= 32'(V_SS)) && (vw < 32'(V_SE));

    assign o_pix_stb     = stb;
    assign o_x           = h;
    assign o_y           = v;
    assign o_active      = (hw < 32'(H_ACTIVE)) && (vw < 32'(V_ACTIVE));
    assign o_line_start  = stb && (h == '0);
    assign o_frame_start = stb && (h == '0) && (v == '0);

    // Raster counters advance per strobe; disable parks them at the origin
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h           <= '0;
            v           <= '0;
            o_frame_cnt <= '0;
        end else if (!i_en) begin
            h <= '0;
            v <= '0;
        end else if (stb) begin
            h <= h_last ? '0 : h + CW'(1);
            if (h_last) begin
                v <= v_last ? '0 : v + CW'(1);
                if (v_last)
                    o_frame_cnt <= o_frame_cnt + FCW'(1);
            end
        end
    end

    // Shared pin register keeps colour and sync aligned, one pixel behind the counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pix_q <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
        end else if (!i_en) begin
            pix_q <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
        end else if (stb) begin
            pix_q <= o_active ? rgb_t'(i_rgb) : '0;
            hs_q  <= hsync ? HS_POL : ~HS_POL;
            vs_q  <= vsync ? VS_POL : ~VS_POL;
        end
    end

    assign VGA_HS_O = hs_q;
    assign VGA_VS_O = vs_q;
    assign VGA_R_O  = pix_q.r;
    assign VGA_G_O  = pix_q.g;
    assign VGA_B_O  = pix_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 line timing plus a tiny 8x6 raster for full frames.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_d, en_d, rst_s, en_s;
    logic [7:0] rgb;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Cycle stamp for interval measurements
    always @(posedge clk) cyc <= cyc + 1;

    // Default-configuration instance
    logic        d_stb, d_act, d_ls, d_fs, d_hs, d_vs;
    logic [9:0]  d_x, d_y;
    logic [15:0] d_fc;
    logic [2:0]  d_r, d_g;
    logic [1:0]  d_b;

    vga_timing_gen u_def (
        .i_clk(clk), .i_rst_n(rst_d), .i_en(en_d), .i_rgb(rgb),
        .o_pix_stb(d_stb), .o_x(d_x), .o_y(d_y), .o_active(d_act),
        .o_line_start(d_ls), .o_frame_start(d_fs), .o_frame_cnt(d_fc),
        .VGA_HS_O(d_hs), .VGA_VS_O(d_vs), .VGA_R_O(d_r), .VGA_G_O(d_g), .VGA_B_O(d_b)
    );

    // Small raster H 4/1/2/1, V 3/1/1/1, one clock per pixel, active-low syncs
    logic       s_stb, s_act, s_ls, s_fs, s_hs, s_vs;
    logic [3:0] s_x, s_y;
    logic [7:0] s_fc;
    logic [2:0] s_r, s_g;
    logic [1:0] s_b;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(1), .CW(4), .FCW(8)
    ) u_sm (
        .i_clk(clk), .i_rst_n(rst_s), .i_en(en_s), .i_rgb(rgb),
        .o_pix_stb(s_stb), .o_x(s_x), .o_y(s_y), .o_active(s_act),
        .o_line_start(s_ls), .o_frame_start(s_fs), .o_frame_cnt(s_fc),
        .VGA_HS_O(s_hs), .VGA_VS_O(s_vs), .VGA_R_O(s_r), .VGA_G_O(s_g), .VGA_B_O(s_b)
    );

    // Same small raster with active-high syncs
    logic       p_stb, p_act, p_ls, p_fs, p_hs, p_vs;
    logic [3:0] p_x, p_y;
    logic [7:0] p_fc;
    logic [2:0] p_r, p_g;
    logic [1:0] p_b;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(1), .CW(4), .FCW(8)
    ) u_smp (
        .i_clk(clk), .i_rst_n(rst_s), .i_en(en_s), .i_rgb(rgb),
        .o_pix_stb(p_stb), .o_x(p_x), .o_y(p_y), .o_active(p_act),
        .o_line_start(p_ls), .o_frame_start(p_fs), .o_frame_cnt(p_fc),
        .VGA_HS_O(p_hs), .VGA_VS_O(p_vs), .VGA_R_O(p_r), .VGA_G_O(p_g), .VGA_B_O(p_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge where the default instance strobes at column x
    task automatic wait_dx(input int x, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (d_stb && d_x == 10'(x)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int cnt, t0, t1, t2, fsave;
        int bad_xy, bad_ctl, bad_hs, bad_vs, bad_px;

        rst_d = 1'b0; rst_s = 1'b0; en_d = 1'b1; en_s = 1'b1; rgb = 8'hFF;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_x", d_x, 0);
        chk("rst_y", d_y, 0);
        chk("rst_fc", d_fc, 0);
        chk("rst_stb", d_stb, 0);
        chk("rst_hs", d_hs, 1);
        chk("rst_vs", d_vs, 1);
        chk("rst_rgb", {d_r, d_g, d_b}, 0);
        chk("rst_pol_hs", p_hs, 0);
        chk("rst_pol_vs", p_vs, 0);

        // First strobe on the 4th edge after release, at the origin
        rst_d = 1'b1; rst_s = 1'b1;
        @(negedge clk); chk("first_stb_e1", d_stb, 0);
        @(negedge clk); chk("first_stb_e2", d_stb, 0);
        @(negedge clk); chk("first_stb_e3", d_stb, 1);
        chk("first_fs", d_fs, 1);
        chk("first_ls", d_ls, 1);
        chk("first_xy", {d_x, d_y}, 0);
        chk("first_act", d_act, 1);
        @(negedge clk);
        chk("pix0_rgb", {d_r, d_g, d_b}, 8'hFF);
        chk("pix0_x", d_x, 1);

        // Colour blanks one pixel after the active area ends
        wait_dx(640, 4000, ok); chk("wait_x640", ok, 1);
        chk("x640_rgb_last_active", {d_r, d_g, d_b}, 8'hFF);
        chk("x640_act", d_act, 0);
        @(negedge clk);
        chk("x640_rgb_blank", {d_r, d_g, d_b}, 0);

        // Hsync falls one pixel after x=656, lasts 384 clocks, period 3200
        wait_dx(656, 200, ok); chk("wait_x656", ok, 1);
        chk("hs_before", d_hs, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); cnt++;
            if (!d_hs) break;
        end
        chk("hs_fall_lag", cnt, 1);
        chk("hs_fall_x", d_x, 657);
        chk("hs_rgb_blank", {d_r, d_g, d_b}, 0);
        t0 = cyc;
        for (int i = 0; i < 5000 && !d_hs; i++) @(negedge clk);
        t1 = cyc;
        chk("hs_low_len", t1 - t0, 384);
        for (int i = 0; i < 5000 && d_hs; i++) @(negedge clk);
        t2 = cyc;
        chk("hs_period", t2 - t0, 3200);
        chk("vs_idle", d_vs, 1);

        // New colour reaches the pins one pixel after line start
        rgb = 8'hA5;
        wait_dx(0, 4000, ok); chk("wait_line2", ok, 1);
        chk("line2_y", d_y, 2);
        chk("line2_ls", d_ls, 1);
        chk("line2_fs", d_fs, 0);
        @(negedge clk);
        chk("line2_rgb", {d_r, d_g, d_b}, 8'hA5);

        // Reset mid-line clears everything at once
        wait_dx(300, 4000, ok); chk("wait_x300", ok, 1);
        chk("pre_rst_rgb", {d_r, d_g, d_b}, 8'hA5);
        rst_d = 1'b0;
        #1;
        chk("mid_rst_xy", {d_x, d_y}, 0);
        chk("mid_rst_rgb", {d_r, d_g, d_b}, 0);
        chk("mid_rst_hs", d_hs, 1);
        @(negedge clk);
        rst_d = 1'b1;
        @(negedge clk); chk("rerun_e1", d_stb, 0);
        @(negedge clk); chk("rerun_e2", d_stb, 0);
        @(negedge clk); chk("rerun_stb", d_stb, 1);
        chk("rerun_fs", d_fs, 1);
        chk("rerun_xy", {d_x, d_y}, 0);

        // Small raster: one full frame against a pixel-by-pixel model
        rgb = 8'h5A;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_fs) begin ok = 1'b1; break; end
        end
        chk("wait_sm_fs", ok, 1);
        bad_xy = 0; bad_ctl = 0; bad_hs = 0; bad_vs = 0; bad_px = 0;
        for (int i = 0; i < 48; i++) begin
            int prev, ph, pv, ex, ey;
            logic ehs, evs, eact;
            if (i > 0) @(negedge clk);
            ex = i % 8; ey = i / 8;
            prev = (i + 47) % 48; ph = prev % 8; pv = prev / 8;
            ehs = (ph >= 5 && ph < 7);
            evs = (pv == 4);
            eact = (ph < 4 && pv < 3);
            if (s_x !== 4'(ex) || s_y !== 4'(ey)) bad_xy++;
            if (s_act !== (ex < 4 && ey < 3) || s_fs !== (i == 0) || s_ls !== (ex == 0) || !s_stb) bad_ctl++;
            if (s_hs !== ~ehs || p_hs !== ehs) bad_hs++;
            if (s_vs !== ~evs || p_vs !== evs) bad_vs++;
            if ({s_r, s_g, s_b} !== (eact ? 8'h5A : 8'h00) || {p_r, p_g, p_b} !== (eact ? 8'h5A : 8'h00)) bad_px++;
        end
        chk("sm_xy_seq", bad_xy, 0);
        chk("sm_ctl_seq", bad_ctl, 0);
        chk("sm_hsync_seq", bad_hs, 0);
        chk("sm_vsync_seq", bad_vs, 0);
        chk("sm_pix_seq", bad_px, 0);
        @(negedge clk);
        chk("sm_fs_period", s_fs, 1);

        // Reset while active-high hsync is asserted drops it immediately
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p_hs) begin ok = 1'b1; break; end
        end
        chk("wait_pol_hs", ok, 1);
        rst_s = 1'b0;
        #1;
        chk("sm_rst_pol_hs", p_hs, 0);
        chk("sm_rst_fc", s_fc, 0);
        @(negedge clk);
        rst_s = 1'b1;
        #1;
        chk("sm_rel_fs", s_fs, 1);

        // Frame counter steps exactly at the 48th clock after release
        repeat (47) @(negedge clk);
        chk("sm_fc_before", s_fc, 0);
        @(negedge clk);
        chk("sm_fc_after", s_fc, 1);

        // Enable dropped mid-frame for 50 clocks
        repeat (13) @(negedge clk);
        fsave = int'(s_fc);
        en_d = 1'b0; en_s = 1'b0;
        #1;
        chk("dis_stb_now", {d_stb, s_stb}, 0);
        bad_ctl = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (d_stb || s_stb || p_stb) bad_ctl++;
            if (d_x != 0 || d_y != 0 || s_x != 0 || s_y != 0) bad_ctl++;
            if ({d_r, d_g, d_b} != 0 || {s_r, s_g, s_b} != 0) bad_ctl++;
            if (!d_hs || !d_vs || !s_hs || !s_vs || p_hs || p_vs) bad_ctl++;
            if (int'(s_fc) != fsave) bad_ctl++;
        end
        chk("dis_blank", bad_ctl, 0);
        chk("dis_fc_held", s_fc, fsave);
        en_d = 1'b1; en_s = 1'b1;
        #1;
        chk("sm_reen_fs", s_fs, 1);
        chk("sm_reen_xy", {s_x, s_y}, 0);
        @(negedge clk); chk("reen_e1", d_stb, 0);
        @(negedge clk); chk("reen_e2", d_stb, 0);
        @(negedge clk); chk("reen_stb", d_stb, 1);
        chk("reen_fs", d_fs, 1);
        chk("reen_xy", {d_x, d_y}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
